// File: rtl/data_bus_ram_if.sv
// rtl/data_bus_ram_if.sv - master/slave data bus between core and RAM
interface data_bus_ram_if;
  logic        busRead;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busDataOut;
  logic        busMemType;
  logic [31:0] busDataIn;
  logic        busReady;
  logic        busErr;

  modport master (
    output busRead, busWrite, busAddr, busDataOut, busMemType,
    input  busDataIn, busReady, busErr
  );

  modport slave (
    input  busRead, busWrite, busAddr, busDataOut, busMemType,
    output busDataIn, busReady, busErr
  );
endinterface

// File: rtl/data_bus_ram.sv
// rtl/data_bus_ram.sv - wait-stated little-endian 32-bit RAM slave on the data bus
// busMemType: 0 selects a word access, 1 a byte access.
module data_bus_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           res,
  data_bus_ram_if.slave bus
);
  localparam logic [1:0]  IDLE       = 2'd0;
  localparam logic [1:0]  WAIT       = 2'd1;
  localparam logic [1:0]  DONE       = 2'd2;
  localparam logic        MEM_BYTE   = 1'b1;
  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAST_WAIT  = 4'(WAIT_CYCLES - 1);
  localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);

  logic [1:0]  state;
  logic [3:0]  waitCnt;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic        byteQ;
  logic        readQ;
  logic        bothQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          doAccess;
  logic [31:0]   acAddr;
  logic [31:0]   acData;
  logic          acByte;
  logic          acRead;
  logic          acBoth;
  logic          inRange;
  logic          misaligned;
  logic          accErr;
  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic          memWe;

  assign req = bus.busRead | bus.busWrite;

  // A zero-wait access completes on its sampling edge, so it must see the live bus.
  always_comb begin
    acAddr = addrQ;
    acData = dataQ;
    acByte = byteQ;
    acRead = readQ;
    acBoth = bothQ;
    if (state == IDLE) begin
      acAddr = bus.busAddr;
      acData = bus.busDataOut;
      acByte = bus.busMemType;
      acRead = bus.busRead;
      acBoth = bus.busRead & bus.busWrite;
    end
  end

  assign doAccess   = res && ((state == IDLE && NO_WAIT && req) ||
                              (state == WAIT && waitCnt == LAST_WAIT));
  assign inRange    = {1'b0, acAddr} < BYTE_LIMIT;
  assign misaligned = (acByte != MEM_BYTE) && (acAddr[1:0] != 2'b00);
  assign accErr     = acBoth | ~inRange | misaligned;
  assign wordIdx    = acAddr[AW+1:2];
  assign lane       = acAddr[1:0];
  assign rdWord     = mem[wordIdx];
  assign rdByte     = rdWord[{lane, 3'b000} +: 8];
  assign memWe      = doAccess && !acRead && !accErr;

  // Storage has no reset so its contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      if (acByte == MEM_BYTE) begin
        mem[wordIdx][{lane, 3'b000} +: 8] <= acData[7:0];
      end else begin
        mem[wordIdx] <= acData;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state         <= IDLE;
      waitCnt       <= 4'd0;
      addrQ         <= 32'd0;
      dataQ         <= 32'd0;
      byteQ         <= 1'b0;
      readQ         <= 1'b0;
      bothQ         <= 1'b0;
      bus.busReady  <= 1'b0;
      bus.busErr    <= 1'b0;
      bus.busDataIn <= 32'd0;
    end else begin
      bus.busReady <= 1'b0;
      bus.busErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addrQ   <= bus.busAddr;
            dataQ   <= bus.busDataOut;
            byteQ   <= bus.busMemType;
            readQ   <= bus.busRead;
            bothQ   <= bus.busRead & bus.busWrite;
            waitCnt <= 4'd0;
            state   <= NO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (doAccess) begin
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (doAccess) begin
        bus.busReady <= 1'b1;
        bus.busErr   <= accErr;
        if (accErr) begin
          bus.busDataIn <= 32'd0;
        end else if (acRead) begin
          bus.busDataIn <= (acByte == MEM_BYTE) ? {24'd0, rdByte} : rdWord;
        end
      end
    end
  end
endmodule
